// File: rtl/vga_board_decoder.sv
// Recovers a 7x6 game board, winner highlights and cursor from a VGA stream
// by locking pixel counters to the incoming syncs and sampling fixed pixels.
module vga_board_decoder #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 524,
  parameter int HS_START   = 656,
  parameter int HS_END     = 751,
  parameter int VS_START   = 491,
  parameter int VS_END     = 492,
  parameter int CELL_X0    = 80,
  parameter int CELL_DX    = 80,
  parameter int CELL_Y0    = 437,
  parameter int CELL_DY    = 80,
  parameter int CURSOR_ROW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [41:0] board_p0,
  output logic [41:0] board_p1,
  output logic [41:0] board_win,
  output logic        win_a,
  output logic        win_b,
  output logic        cursor_valid,
  output logic [2:0]  cursor_col,
  output logic        cursor_player,
  output logic        frame_valid,
  output logic        locked,
  output logic        sync_error,
  output logic [7:0]  err_cnt
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_nx;
  logic        hs_q, vs_q, vs_prev;
  logic [11:0] rgb_q;
  logic [9:0]  col, row;
  logic        phase;
  logic [41:0] sh_p0, sh_p1, sh_win;
  logic        sh_wa, sh_wb, sh_cv, sh_cp;
  logic [2:0]  sh_cc;
  logic        col_hit, row_hit;
  logic [2:0]  col_m, row_n;
  logic [5:0]  cell_k;
  logic        last, hs_exp, vs_exp, sync_bad;
  logic        detect, mismatch, sample, update, clear;
  logic        is_blue, is_red, is_cyan, is_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      vs_prev <= 1'b1;
      rgb_q   <= '0;
    end else begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      vs_prev <= vs_q;
      rgb_q   <= {red, green, blue};
    end
  end

  // Sample-point lookup: which board column / row the current pixel sits on.
  always_comb begin
    col_hit = 1'b0;
    col_m   = '0;
    row_hit = 1'b0;
    row_n   = '0;
    for (int m = 0; m < 7; m++)
      if (col == 10'(CELL_X0 + CELL_DX * m)) begin
        col_hit = 1'b1;
        col_m   = 3'(m);
      end
    for (int n = 0; n < 6; n++)
      if (row == 10'(CELL_Y0 - CELL_DY * n)) begin
        row_hit = 1'b1;
        row_n   = 3'(n);
      end
  end

  assign cell_k   = {3'b0, col_m} + 6'd7 * {3'b0, row_n};
  assign last     = (row == 10'(V_TOTAL - 1)) && (col == 10'(H_TOTAL - 1)) && phase;
  assign hs_exp   = !((col >= 10'(HS_START)) && (col <= 10'(HS_END)));
  assign vs_exp   = !((row >= 10'(VS_START)) && (row <= 10'(VS_END)));
  assign sync_bad = (hs_q != hs_exp) || (vs_q != vs_exp);
  assign is_blue  = (rgb_q == 12'h00F);
  assign is_red   = (rgb_q == 12'hF00);
  assign is_cyan  = (rgb_q == 12'h0FF);
  assign is_mag   = (rgb_q == 12'hF0F);
  assign clear    = detect || ((state != SEARCH) && last);

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SEARCH:  if (detect) state_nx = ACQUIRE;
      ACQUIRE: if (mismatch) state_nx = SEARCH;
               else if (last) state_nx = LOCKED;
      LOCKED:  if (mismatch) state_nx = SEARCH;
      default: state_nx = SEARCH;
    endcase
  end

  // An error on the final cycle suppresses that frame's update.
  always_comb begin
    detect   = 1'b0;
    mismatch = 1'b0;
    sample   = 1'b0;
    update   = 1'b0;
    locked   = 1'b0;
    case (state)
      SEARCH:  detect = vs_prev && !vs_q;
      ACQUIRE: begin
        mismatch = sync_bad;
        sample   = !phase;
      end
      LOCKED:  begin
        mismatch = sync_bad;
        sample   = !phase;
        update   = last && !sync_bad;
        locked   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0; row <= '0; phase <= 1'b0;
      sh_p0 <= '0; sh_p1 <= '0; sh_win <= '0;
      sh_wa <= 1'b0; sh_wb <= 1'b0; sh_cv <= 1'b0; sh_cc <= '0; sh_cp <= 1'b0;
      board_p0 <= '0; board_p1 <= '0; board_win <= '0;
      win_a <= 1'b0; win_b <= 1'b0;
      cursor_valid <= 1'b0; cursor_col <= '0; cursor_player <= 1'b0;
      frame_valid <= 1'b0; sync_error <= 1'b0; err_cnt <= '0;
    end else begin
      frame_valid <= update;
      sync_error  <= mismatch;
      if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      // The detect cycle is pixel (VS_START, 0) phase 0, so load its successor.
      if (detect) begin
        col <= '0; row <= 10'(VS_START); phase <= 1'b1;
      end else begin
        phase <= !phase;
        if (phase) begin
          if (col == 10'(H_TOTAL - 1)) begin
            col <= '0;
            row <= (row == 10'(V_TOTAL - 1)) ? '0 : row + 10'd1;
          end else begin
            col <= col + 10'd1;
          end
        end
      end

      if (sample && col_hit && row_hit) begin
        sh_p0[cell_k]  <= is_blue;
        sh_p1[cell_k]  <= is_red;
        sh_win[cell_k] <= is_cyan || is_mag;
        if (is_cyan) sh_wa <= 1'b1;
        if (is_mag)  sh_wb <= 1'b1;
      end
      // Columns are visited left to right, so the first lit one is kept.
      if (sample && col_hit && row == 10'(CURSOR_ROW) && !sh_cv && (is_blue || is_red)) begin
        sh_cv <= 1'b1;
        sh_cc <= col_m;
        sh_cp <= is_red;
      end

      if (update) begin
        board_p0 <= sh_p0; board_p1 <= sh_p1; board_win <= sh_win;
        win_a <= sh_wa; win_b <= sh_wb;
        cursor_valid <= sh_cv; cursor_col <= sh_cc; cursor_player <= sh_cp;
      end
      if (clear) begin
        sh_p0 <= '0; sh_p1 <= '0; sh_win <= '0;
        sh_wa <= 1'b0; sh_wb <= 1'b0; sh_cv <= 1'b0; sh_cc <= '0; sh_cp <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vga_board_decoder.sv
// Directed bench: a small-geometry VGA driver paints board/cursor pixels and
// each task checks the decoded outputs against hand-computed values.
module tb_vga_board_decoder;
  localparam int H = 40, V = 30, HS0 = 32, HS1 = 35, VS0 = 25, VS1 = 26;
  localparam int X0 = 4, DX = 4, Y0 = 22, DY = 3, CR = 2;
  localparam int FRAME = 2 * H * V;

  logic clk = 1'b0, rst, hsync, vsync;
  logic [3:0] red, green, blue;
  logic [41:0] board_p0, board_p1, board_win;
  logic win_a, win_b, cursor_valid, cursor_player, frame_valid, locked, sync_error;
  logic [2:0] cursor_col;
  logic [7:0] err_cnt;

  int checks = 0, errors = 0;
  int drow = 0, dcol = 0, dph = 0, nsteps = 0, fv_seen = 0, se_seen = 0;
  bit late_pending = 1'b0, sat_mode = 1'b0;
  logic [11:0] cell_rgb [42];
  logic [11:0] cur_rgb [7];

  vga_board_decoder #(
    .H_TOTAL(H), .V_TOTAL(V), .HS_START(HS0), .HS_END(HS1), .VS_START(VS0), .VS_END(VS1),
    .CELL_X0(X0), .CELL_DX(DX), .CELL_Y0(Y0), .CELL_DY(DY), .CURSOR_ROW(CR)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .board_p0(board_p0), .board_p1(board_p1), .board_win(board_win),
    .win_a(win_a), .win_b(win_b), .cursor_valid(cursor_valid),
    .cursor_col(cursor_col), .cursor_player(cursor_player),
    .frame_valid(frame_valid), .locked(locked), .sync_error(sync_error), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix(int r, int c);
    logic [11:0] v;
    v = '0;
    for (int m = 0; m < 7; m++)
      for (int n = 0; n < 6; n++)
        if (c == X0 + DX * m && r == Y0 - DY * n) v = cell_rgb[m + 7 * n];
    if (r <= 4)
      for (int z = 0; z < 7; z++)
        if (c >= X0 + DX * z - 1 && c <= X0 + DX * z + 1) v = cur_rgb[z];
    return v;
  endfunction

  task automatic step();
    {red, green, blue} = pix(drow, dcol);
    hsync = !(dcol >= HS0 && dcol <= HS1);
    if (late_pending && dcol == HS0) hsync = 1'b1;
    vsync = !(drow >= VS0 && drow <= VS1);
    if (sat_mode) begin
      hsync = 1'b0;
      vsync = (nsteps % 2 == 1);
    end
    @(posedge clk); #1;
    nsteps++;
    if (frame_valid) fv_seen++;
    if (sync_error) se_seen++;
    if (late_pending && dcol == HS0 && dph == 1) late_pending = 1'b0;
    if (dph == 1) begin
      if (dcol == H - 1) begin
        dcol = 0;
        drow = (drow == V - 1) ? 0 : drow + 1;
      end else dcol++;
    end
    dph = 1 - dph;
  endtask

  task automatic wait_fv(input int budget, output int n);
    int f0;
    f0 = fv_seen;
    n = 0;
    while (fv_seen == f0 && n < budget) begin
      step();
      n++;
    end
    if (fv_seen == f0) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; {red, green, blue} = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({board_p0, board_p1, board_win} !== 126'd0) begin errors++;
      $display("FAIL reset_board: got %0h want 0", {board_p0, board_p1, board_win}); end
    checks++; if ({win_a, win_b, cursor_valid, cursor_col, cursor_player, frame_valid, locked, sync_error} !== 10'd0) begin errors++;
      $display("FAIL reset_flags: got %0h want 0", {win_a, win_b, cursor_valid, cursor_col, cursor_player, frame_valid, locked, sync_error}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    logic [41:0] e;
    cell_rgb[0] = 12'h00F; cell_rgb[41] = 12'hF00;
    wait_fv(3 * FRAME, n);
    checks++; if (n !== 2 * FRAME + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n, 2 * FRAME + 1); end
    e = '0; e[0] = 1'b1;
    checks++; if (board_p0 !== e) begin errors++; $display("FAIL basic_p0: got %0h want %0h", board_p0, e); end
    e = '0; e[41] = 1'b1;
    checks++; if (board_p1 !== e) begin errors++; $display("FAIL basic_p1: got %0h want %0h", board_p1, e); end
    checks++; if ({board_win, win_a, win_b, cursor_valid} !== 45'd0) begin errors++;
      $display("FAIL basic_win_cursor: got %0h want 0", {board_win, win_a, win_b, cursor_valid}); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked: got %0b want 1", locked); end
    step();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_fv_pulse: got %0b want 0", frame_valid); end
  endtask

  task automatic test_win();
    int n;
    logic [41:0] e;
    for (int k = 0; k < 4; k++) cell_rgb[k] = 12'h0FF;
    wait_fv(FRAME + 10, n);
    checks++; if (n !== FRAME - 1) begin errors++; $display("FAIL win_latency: got %0d want %0d", n, FRAME - 1); end
    checks++; if (board_win !== 42'hF) begin errors++; $display("FAIL win_cyan_map: got %0h want f", board_win); end
    checks++; if ({win_a, win_b} !== 2'b10) begin errors++; $display("FAIL win_cyan_flags: got %b want 10", {win_a, win_b}); end
    e = '0; e[41] = 1'b1;
    checks++; if ({board_p0, board_p1} !== {42'd0, e}) begin errors++;
      $display("FAIL win_cyan_players: got %0h/%0h want 0/%0h", board_p0, board_p1, e); end
    for (int k = 0; k < 4; k++) cell_rgb[k] = 12'h000;
    cell_rgb[10] = 12'hF0F;
    wait_fv(FRAME + 10, n);
    e = '0; e[10] = 1'b1;
    checks++; if (board_win !== e) begin errors++; $display("FAIL win_mag_map: got %0h want %0h", board_win, e); end
    checks++; if ({win_a, win_b, board_p0} !== {2'b01, 42'd0}) begin errors++;
      $display("FAIL win_mag_flags: got %b %0h want 01 0", {win_a, win_b}, board_p0); end
  endtask

  task automatic test_cursor();
    int n;
    cur_rgb[3] = 12'hF00; cur_rgb[5] = 12'h00F;
    wait_fv(FRAME + 10, n);
    checks++; if (n !== FRAME) begin errors++; $display("FAIL cursor_latency: got %0d want %0d", n, FRAME); end
    checks++; if ({cursor_valid, cursor_col, cursor_player} !== {1'b1, 3'd3, 1'b1}) begin errors++;
      $display("FAIL cursor_red3: got %b/%0d/%b want 1/3/1", cursor_valid, cursor_col, cursor_player); end
    cur_rgb[1] = 12'h00F; cur_rgb[0] = 12'h0F0;
    wait_fv(FRAME + 10, n);
    checks++; if ({cursor_valid, cursor_col, cursor_player} !== {1'b1, 3'd1, 1'b0}) begin errors++;
      $display("FAIL cursor_lowest: got %b/%0d/%b want 1/1/0", cursor_valid, cursor_col, cursor_player); end
    for (int z = 0; z < 7; z++) cur_rgb[z] = 12'h000;
    wait_fv(FRAME + 10, n);
    checks++; if (cursor_valid !== 1'b0) begin errors++; $display("FAIL cursor_removed: got %b want 0", cursor_valid); end
  endtask

  task automatic test_sync_error();
    int n, f0, s0;
    logic [41:0] e;
    e = '0; e[10] = 1'b1;
    f0 = fv_seen; s0 = se_seen;
    late_pending = 1'b1;
    repeat (200) step();
    checks++; if (se_seen - s0 !== 1) begin errors++; $display("FAIL serr_pulses: got %0d want 1", se_seen - s0); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL serr_cnt: got %0d want 1", err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL serr_unlock: got %b want 0", locked); end
    checks++; if (board_win !== e) begin errors++; $display("FAIL serr_hold: got %0h want %0h", board_win, e); end
    repeat (FRAME - 200) step();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL serr_relock: got %b want 1", locked); end
    checks++; if (fv_seen !== f0) begin errors++; $display("FAIL serr_no_update: got %0d want %0d", fv_seen, f0); end
    wait_fv(FRAME + 10, n);
    checks++; if (n !== FRAME) begin errors++; $display("FAIL serr_resume: got %0d want %0d", n, FRAME); end
  endtask

  task automatic test_reset_midframe();
    int n, idx;
    logic [41:0] e;
    repeat (2 * H * 12 - 1) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({board_p1, board_win, win_b, err_cnt, locked, frame_valid} !== 95'd0) begin errors++;
      $display("FAIL rstmid_clear: got %0h/%0h/%b/%0d/%b/%b want all 0", board_p1, board_win, win_b, err_cnt, locked, frame_valid); end
    idx = drow * 2 * H + dcol * 2 + dph;
    wait_fv(3 * FRAME, n);
    checks++; if (n !== 2 * FRAME - idx + 1) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", n, 2 * FRAME - idx + 1); end
    e = '0; e[41] = 1'b1;
    checks++; if (board_p1 !== e) begin errors++; $display("FAIL rstmid_board: got %0h want %0h", board_p1, e); end
  endtask

  task automatic test_saturate();
    int s0;
    s0 = se_seen;
    sat_mode = 1'b1;
    repeat (600) step();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d want 255", err_cnt); end
    repeat (200) step();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
    checks++; if (!(se_seen - s0 > 255)) begin errors++; $display("FAIL sat_pulses: got %0d want >255", se_seen - s0); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sat_locked: got %b want 0", locked); end
    sat_mode = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 42; k++) cell_rgb[k] = 12'h000;
    for (int z = 0; z < 7; z++) cur_rgb[z] = 12'h000;
    test_reset();
    test_basic();
    test_win();
    test_cursor();
    test_sync_error();
    test_reset_midframe();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_board_decoder.md
VGA_BOARD_DECODER -- requirements
Module: vga_board_decoder

Interface
REQ-001 Parameter H_TOTAL, default 800, pixels per line.
REQ-002 Parameter V_TOTAL, default 524, lines per frame.
REQ-003 Parameter HS_START/HS_END, default 656/751, hsync-low pixel range, inclusive.
REQ-004 Parameter VS_START/VS_END, default 491/492, vsync-low line range, inclusive.
REQ-005 clk  in  1  system clock; pixel rate = clk/2.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 hsync, vsync  in  1 each  sync inputs from the display driver, synchronous to clk.
REQ-008 red, green, blue  in  4 each  pixel colour, synchronous to clk.
REQ-009 board_p0, board_p1, board_win  out  42 each  decoded cell maps; index k = m + 7n, where m is the column (0..6) and n is the row from the bottom (0..5).
REQ-010 win_a, win_b  out  1 each  a cyan or magenta winner cell was seen in the last frame.
REQ-011 cursor_valid  out  1; cursor_col  out  3; cursor_player  out  1  decoded cursor.
REQ-012 frame_valid  out  1  one-cycle pulse when the outputs update.
REQ-013 locked  out  1  high in LOCKED state.
REQ-014 sync_error  out  1  one-cycle pulse on a sync mismatch.
REQ-015 err_cnt  out  8  saturating count of sync errors.

Function
REQ-016 All inputs shall be registered once (hs_q, vs_q, rgb_q); all decoding shall use the registered values.
REQ-017 Internal state shall be col (10 b), row (10 b) and phase (1 b).
- phase toggles every cycle.
- col increments when phase = 1 and wraps from H_TOTAL-1 to 0.
- On that col wrap, row increments and wraps from V_TOTAL-1 to 0.
REQ-018 The FSM shall have three states: SEARCH, ACQUIRE, LOCKED.
REQ-019 SEARCH: on vs_q = 0 while the previous vs_q = 1, the detect cycle shall be pixel (row 491, col 0), phase 0, and the FSM shall go to ACQUIRE.
REQ-020 In ACQUIRE and LOCKED, every cycle shall compare hs_q and vs_q against the values expected from col and row.
- Any mismatch: sync_error pulses for 1 cycle and err_cnt increments (saturating at 255).
- On a mismatch the FSM returns to SEARCH; the board outputs are retained.
REQ-021 ACQUIRE shall go to LOCKED after an error-free wrap from (V_TOTAL-1, H_TOTAL-1, phase 1) to (0, 0, 0).
REQ-022 Cell sampling shall occur at phase 0 of pixel (col = 80 + 80m, row = 437 - 80n), writing shadow bit k.
REQ-023 Colour decode shall use an exact 12-bit match on {r, g, b}:
- 0/0/F: p0 bit set.
- F/0/0: p1 bit set.
- 0/F/F: win bit set, win_a flag set.
- F/0/F: win bit set, win_b flag set.
- Any other value: all three bits cleared for that cell.
REQ-024 Cursor sampling shall occur at phase 0 of pixel (row 2, col 80 + 80z) for z = 0..6.
- 0/0/F decodes as player 0; F/0/0 decodes as player 1.
- The lowest lit z wins.
- No lit z: shadow cursor_valid = 0.
REQ-025 At the last cycle of the frame (row V_TOTAL-1, col H_TOTAL-1, phase 1) in LOCKED only:
- The shadows shall copy to the outputs and frame_valid shall pulse.
- The shadows and winner flags shall then clear.
REQ-026 Outputs shall update no more than once per frame.
- In ACQUIRE no update occurs; the shadows still fill.
- If an error falls in the final cycle, the error takes precedence and no update occurs.
REQ-027 The latency from a sampled pixel reaching the inputs to its frame's outputs shall be 1 input-register cycle plus the remaining frame time plus 1 cycle.

Reset
REQ-028 While rst = 1 at a clk edge:
- All outputs, err_cnt, the shadows, col, row and phase shall be set to 0.
- The FSM shall be set to SEARCH.
- The input registers shall be set to hs_q = vs_q = 1 and rgb_q = 0.
REQ-029 Reset asserted mid-frame shall abort the frame with no frame_valid; decoding shall resume only after a new vsync falling edge.

Verification
REQ-030 Drive a compliant 800x524 stream (clk/2) that is all-black except cell 0 blue and cell 41 red -> frame_valid on the second complete frame after the first vsync fall, with board_p0 = 1<<0 and board_p1 = 1<<41.
REQ-031 Paint cells 0..3 cyan (a bottom-row win) -> board_win = 0xF, win_a = 1, win_b = 0; board_p0 and board_p1 bits 0..3 = 0.
REQ-032 Cursor red at cols 283..357, rows 0..4 -> cursor_valid = 1, cursor_col = 3, cursor_player = 1; cursor removed -> cursor_valid = 0 in the next frame.
REQ-033 While locked, shift one hsync fall 2 clks late -> sync_error pulses, err_cnt = 1, locked = 0, and the board outputs hold their values; relock after 1 clean frame.
REQ-034 Hold hsync low indefinitely -> err_cnt saturates at 255 and never wraps.
REQ-035 Assert rst for 1 cycle at row 300 -> all outputs 0 and no frame_valid until 2 frames after the next vsync fall.
